// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters gated by a synchronised
// PLL lock, producing registered syncs, data enable, pixel coordinates and start pulses.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE);
    localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE);
    localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

    // Half-open window test [lo, hi) used for both sync pulses.
    function automatic logic in_win(input logic [9:0] val, input logic [9:0] lo,
                                    input logic [9:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

    logic [1:0] sync_r;
    logic       run_s;
    logic [9:0] h_cnt_r, v_cnt_r;
    logic [9:0] h_nxt_s, v_nxt_s;

    logic       hsync_s, vsync_s, de_s, line_start_s, frame_start_s;
    logic [9:0] x_s, y_s;
    logic       hsync_r, vsync_r, de_r, line_start_r, frame_start_r;
    logic [9:0] x_r, y_r;

    assign run_s = sync_r[1];

    // Two-flop synchroniser bringing the PLL lock flag into the pixel clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], locked};
        end
    end

    // Next counter state; losing run parks both counters at the frame origin.
    always_comb begin
        h_nxt_s = 10'd0;
        v_nxt_s = 10'd0;
        if (!run_s) begin
            h_nxt_s = 10'd0;
            v_nxt_s = 10'd0;
        end else if (h_cnt_r == H_LAST) begin
            h_nxt_s = 10'd0;
            if (v_cnt_r == V_LAST) begin
                v_nxt_s = 10'd0;
            end else begin
                v_nxt_s = v_cnt_r + 10'd1;
            end
        end else begin
            h_nxt_s = h_cnt_r + 10'd1;
            v_nxt_s = v_cnt_r;
        end
    end

    // Horizontal and vertical position counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= 10'd0;
        end else begin
            h_cnt_r <= h_nxt_s;
            v_cnt_r <= v_nxt_s;
        end
    end

    // Decode the current counter state into next output values.
    always_comb begin
        hsync_s       = ~SYNC_POL;
        vsync_s       = ~SYNC_POL;
        de_s          = 1'b0;
        x_s           = 10'd0;
        y_s           = 10'd0;
        line_start_s  = 1'b0;
        frame_start_s = 1'b0;
        if (run_s) begin
            de_s          = (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);
            hsync_s       = in_win(h_cnt_r, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync_s       = in_win(v_cnt_r, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
            line_start_s  = (h_cnt_r == 10'd0);
            frame_start_s = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
            if (de_s) begin
                x_s = h_cnt_r;
                y_s = v_cnt_r;
            end else begin
                x_s = 10'd0;
                y_s = 10'd0;
            end
        end else begin
            hsync_s       = ~SYNC_POL;
            vsync_s       = ~SYNC_POL;
            de_s          = 1'b0;
        end
    end

    // Output registers; reset drives the idle levels without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            de_r          <= 1'b0;
            x_r           <= 10'd0;
            y_r           <= 10'd0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            hsync_r       <= hsync_s;
            vsync_r       <= vsync_s;
            de_r          <= de_s;
            x_r           <= x_s;
            y_r           <= y_s;
            line_start_r  <= line_start_s;
            frame_start_r <= frame_start_s;
        end
    end

    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign de          = de_r;
    assign x           = x_r;
    assign y           = y_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 Parameter SYNC_POL, default 0, asserted level of hsync/vsync (0 = active-low).
REQ-010 clk  input  1  pixel clock (25.2 MHz outclk_0 of the pixel-clock PLL).
REQ-011 rst  input  1  asynchronous, active-low reset.
REQ-012 locked  input  1  PLL lock flag, asynchronous to clk.
REQ-013 hsync  output  1  horizontal sync.
REQ-014 vsync  output  1  vertical sync.
REQ-015 de  output  1  data enable, high during visible pixels.
REQ-016 x  output  10  pixel column, valid when de=1.
REQ-017 y  output  10  pixel row, valid when de=1.
REQ-018 line_start  output  1  one-cycle pulse at first pixel of every line (h_cnt=0).
REQ-019 frame_start  output  1  one-cycle pulse at first pixel of frame (h_cnt=0, v_cnt=0).

Function
REQ-020 locked SHALL pass through a 2-flop synchroniser; run = synchronised locked.
REQ-021 Internal h_cnt (10 bit) SHALL count 0..H_TOTAL-1, H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800), then wrap to 0.
REQ-022 Internal v_cnt (10 bit) SHALL increment only when h_cnt wraps; count 0..V_TOTAL-1, V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525), then wrap to 0.
REQ-023 Simultaneous h and v wrap (h_cnt=799, v_cnt=524) SHALL set both to 0 on the next clk.
REQ-024 While run=0, h_cnt and v_cnt SHALL be held at 0 and all outputs forced to idle values (REQ-031).
REQ-025 Loss of run mid-frame SHALL restart from h_cnt=v_cnt=0 on next run=1; no partial-frame resume.
REQ-026 Outputs SHALL be registered; each output reflects the counter state of the previous cycle (1 clk latency).
REQ-027 de SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; x=h_cnt, y=v_cnt when de=1, else x=y=0.
REQ-028 hsync SHALL equal SYNC_POL iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751), else ~SYNC_POL.
REQ-029 vsync SHALL equal SYNC_POL iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), else ~SYNC_POL, for all h_cnt on those lines.
REQ-030 line_start SHALL pulse for every line incl. blanking lines; frame_start SHALL coincide with one line_start per frame.

Reset
REQ-031 On rst=0: synchroniser flops, h_cnt, v_cnt = 0; hsync=vsync=~SYNC_POL; de=0; x=y=0; line_start=frame_start=0; effective immediately, no clk required.
REQ-032 After rst release, counting SHALL begin no earlier than 2 clk edges after locked=1 is sampled (synchroniser delay).

Verification
REQ-033 Reset then locked=1 held -> first frame_start exactly 3 clks after first edge sampling locked; de=1, x=0, y=0 same cycle.
REQ-034 Free-run 2 frames -> frame_start period 420000 clks; line_start period 800; de high 640 clks/line for 480 lines; 307200 de cycles/frame.
REQ-035 Check line 0 -> hsync low exactly for x-positions 656..751 (96 clks); vsync low exactly for lines 490 and 491 (1600 clks).
REQ-036 Drop locked at v_cnt=200, h_cnt=300 for 10 clks -> within 3 clks outputs idle; after re-lock, next frame_start with y=0, no line 201 emitted.
REQ-037 Assert rst mid-line without clk edge -> outputs idle immediately; release with locked=1 -> frame_start after synchroniser latency.
REQ-038 Override SYNC_POL=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 -> line 14 clks, frame 98 clks, hsync high for h_cnt 10..11.
